// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter
//
// Two-master Wishbone classic arbiter in front of the shared 16-bit SRAM
// slave port. Master 0 is the CPU data port. Master 1 is a second bus
// master such as DMA or video fetch. Grants alternate round-robin on ties.
// A grant stays locked while the granted master holds cyc.
//
// Build option: define WB_ARB_TIMEOUT_EN to add a watchdog. If the slave
// leaves a strobe unanswered for TIMEOUT cycles, the watchdog errors the
// transfer and returns the arbiter to IDLE.
//
// Parameters:
//   XLEN      data width of every data bus
//   ADDR_BITS slave byte-address space (word address is [ADDR_BITS-1:2])
//   TIMEOUT   watchdog limit in cycles (only with WB_ARB_TIMEOUT_EN)
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   m0_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   master 0 request
//   m0_dat_o/ack_o/err_o                    master 0 response
//   m1_*                                    same set for master 1
//   s_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o    request to the SRAM slave
//   s_dat_i/ack_i/err_i                     response from the SRAM slave
//   gnt_o                                   one-hot grant, 00 when idle
module wb_sram_arbiter #(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 17,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [3:0]             m0_sel_i,
    input  logic [ADDR_BITS-1:2]   m0_adr_i,
    input  logic [XLEN-1:0]        m0_dat_i,
    output logic [XLEN-1:0]        m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [3:0]             m1_sel_i,
    input  logic [ADDR_BITS-1:2]   m1_adr_i,
    input  logic [XLEN-1:0]        m1_dat_i,
    output logic [XLEN-1:0]        m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [3:0]             s_sel_o,
    output logic [ADDR_BITS-1:2]   s_adr_o,
    output logic [XLEN-1:0]        s_dat_o,
    input  logic [XLEN-1:0]        s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,

    output logic [1:0]             gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last;
    logic   last_next;
    logic   req0;
    logic   req1;
    logic   timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    // Every grant passes through IDLE, so clearing the counter in IDLE also
    // clears it on each new grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || s_ack_i || s_err_i) begin
            tmo_cnt <= '0;
        end else if (s_stb_o) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT));
`else
    // Without the watchdog the arbiter waits for the slave indefinitely.
    // TIMEOUT is accepted for interface compatibility but builds nothing.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end

    assign timeout = 1'b0;
`endif

    // State register and round-robin pointer. After reset, last points at
    // master 1, so master 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // Next-state logic. On a tie the arbiter grants the master that was not
    // granted last. A BUS state stays until its master drops cyc (or the
    // watchdog fires), and always returns to IDLE first.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last)) begin
                    state_next = BUS0;
                    last_next  = 1'b0;
                end else if (req1) begin
                    state_next = BUS1;
                    last_next  = 1'b1;
                end
            end
            BUS0: begin
                if (!m0_cyc_i || timeout) begin
                    state_next = IDLE;
                end
            end
            BUS1: begin
                if (!m1_cyc_i || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output mux. These outputs come straight from the state register. They
    // are also held at zero while rst_i is high, so a reset mid-transfer
    // drops the slave cycle and suppresses any late ack.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (!rst_i) begin
            case (state)
                BUS0: begin
                    s_cyc_o  = m0_cyc_i & ~timeout;
                    s_stb_o  = m0_stb_i & ~timeout;
                    s_we_o   = m0_we_i;
                    s_sel_o  = m0_sel_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_ack_o = s_ack_i & ~timeout;
                    m0_err_o = s_err_i | timeout;
                end
                BUS1: begin
                    s_cyc_o  = m1_cyc_i & ~timeout;
                    s_stb_o  = m1_stb_i & ~timeout;
                    s_we_o   = m1_we_i;
                    s_sel_o  = m1_sel_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_ack_o = s_ack_i & ~timeout;
                    m1_err_o = s_err_i | timeout;
                end
                default: ;
            endcase
        end
    end

    // Both masters see the read data. Only the granted master's ack
    // qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign gnt_o = {state == BUS1, state == BUS0};

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed testbench for wb_sram_arbiter with per-master scoreboards.
// Expected terminations are queued when a request is driven. They are
// popped when the bench drives the slave response and checks the DUT.
module tb_wb_sram_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [16:2] m0_adr_i;
    logic [31:0] m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [16:2] m1_adr_i;
    logic [31:0] m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [16:2] s_adr_o;
    logic [31:0] s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        isErr;
        logic [31:0] data;
    } sb_t;

    sb_t sbQ0[$];
    sb_t sbQ1[$];

    wb_sram_arbiter #(.XLEN(32), .ADDR_BITS(17), .TIMEOUT(15)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_sel_i (m0_sel_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge. Outputs are sampled
    // on the falling edge.
    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                                 input logic we, input logic [3:0] sel,
                                 input logic [14:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input int m, input logic isErr, input logic [31:0] data);
        sb_t e;
        e.isErr = isErr;
        e.data  = data;
        if (m == 0) sbQ0.push_back(e);
        else        sbQ1.push_back(e);
    endtask

    function automatic logic [31:0] termVec();
        return {28'd0, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
    endfunction

    // Pops the oldest expectation for master m. The termination vector must
    // show exactly that master's ack or err. Read data is also compared.
    task automatic checkTermination(input int m, input string tag);
        sb_t         e;
        logic [31:0] rdata;
        if ((m == 0 && sbQ0.size() == 0) || (m == 1 && sbQ1.size() == 0)) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: observed=termination expected=queued entry", tag);
        end else begin
            if (m == 0) e = sbQ0.pop_front();
            else        e = sbQ1.pop_front();
            checkOutput({tag, "_term"}, termVec(), 32'd1 << (m * 2 + int'(e.isErr)));
            if (!e.isErr) begin
                rdata = (m == 0) ? m0_dat_o : m1_dat_o;
                checkOutput({tag, "_data"}, rdata, e.data);
            end
        end
    endtask

    task automatic applyReset();
        nextCycle();
        rst_i = 1'b1;
        sample();
        checkOutput("rst_scyc_during", 32'(s_cyc_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
        checkOutput("rst_term", termVec(), 32'd0);
        nextCycle();
        rst_i = 1'b0;
        sample();
        checkOutput("rst_gnt_after", 32'(gnt_o), 32'd0);
        checkOutput("rst_stb_after", 32'(s_stb_o), 32'd0);
    endtask

    initial begin
        rst_i   = 1'b1;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        applyReset();

        // Single master read with a slave that acks two cycles after stb.
        nextCycle();
        applyStimulus(0, 1, 1, 0, 4'hF, 15'h100, 32'h0);
        pushExpect(0, 1'b0, 32'hDEADBEEF);
        sample();
        checkOutput("t1_idle_stb", 32'(s_stb_o), 32'd0);
        checkOutput("t1_idle_adr", 32'(s_adr_o), 32'd0);
        checkOutput("t1_idle_gnt", 32'(gnt_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t1_stb", 32'(s_stb_o), 32'd1);
        checkOutput("t1_gnt", 32'(gnt_o), 32'd1);
        checkOutput("t1_adr", 32'(s_adr_o), 32'h100);
        checkOutput("t1_wait0", termVec(), 32'd0);
        nextCycle();
        sample();
        checkOutput("t1_wait1", termVec(), 32'd0);
        nextCycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        sample();
        checkTermination(0, "t1_read");
        nextCycle();
        s_ack_i = 1'b0;
        s_dat_i = '0;
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        checkOutput("t1_rel_gnt", 32'(gnt_o), 32'd1);
        checkOutput("t1_rel_cyc", 32'(s_cyc_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t1_idle_again", 32'(gnt_o), 32'd0);

        // Simultaneous requests after reset: m0 first, then m1, then m0
        // wins the next tie.
        applyReset();
        nextCycle();
        applyStimulus(0, 1, 1, 0, 4'hF, 15'h010, 32'h0);
        applyStimulus(1, 1, 1, 0, 4'hF, 15'h020, 32'h0);
        pushExpect(0, 1'b0, 32'h11111111);
        pushExpect(1, 1'b0, 32'h22222222);
        sample();
        checkOutput("t2_idle_gnt", 32'(gnt_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t2_tie_m0", 32'(gnt_o), 32'd1);
        checkOutput("t2_adr_m0", 32'(s_adr_o), 32'h010);
        nextCycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'h11111111;
        sample();
        checkTermination(0, "t2_m0");
        nextCycle();
        s_ack_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        checkOutput("t2_rel_gnt", 32'(gnt_o), 32'd1);
        checkOutput("t2_rel_term", termVec(), 32'd0);
        nextCycle();
        sample();
        checkOutput("t2_gap_gnt", 32'(gnt_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t2_m1_gnt", 32'(gnt_o), 32'd2);
        checkOutput("t2_adr_m1", 32'(s_adr_o), 32'h020);
        nextCycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'h22222222;
        sample();
        checkTermination(1, "t2_m1");
        nextCycle();
        s_ack_i = 1'b0;
        applyStimulus(1, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        applyStimulus(0, 1, 1, 0, 4'hF, 15'h030, 32'h0);
        pushExpect(0, 1'b0, 32'h33333333);
        sample();
        nextCycle();
        applyStimulus(1, 1, 1, 0, 4'hF, 15'h040, 32'h0);
        pushExpect(1, 1'b0, 32'h44444444);
        sample();
        checkOutput("t2_idle2_gnt", 32'(gnt_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t2_alt_m0", 32'(gnt_o), 32'd1);
        checkOutput("t2_alt_adr", 32'(s_adr_o), 32'h030);
        nextCycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'h33333333;
        sample();
        checkTermination(0, "t2_m0b");
        nextCycle();
        s_ack_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        nextCycle();
        // m0 queues a byte-lane write while m1 is still pending.
        applyStimulus(0, 1, 1, 1, 4'b1100, 15'h050, 32'hCAFEF00D);
        pushExpect(0, 1'b1, 32'h0);
        sample();
        checkOutput("t3_idle_gnt", 32'(gnt_o), 32'd0);

        // Lock: m1 keeps cyc across two beats while m0 waits.
        nextCycle();
        sample();
        checkOutput("t3_m1_gnt", 32'(gnt_o), 32'd2);
        checkOutput("t3_adr1", 32'(s_adr_o), 32'h040);
        nextCycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'h44444444;
        sample();
        checkTermination(1, "t3_beat1");
        nextCycle();
        s_ack_i = 1'b0;
        applyStimulus(1, 1, 0, 0, 4'hF, 15'h040, 32'h0);
        sample();
        checkOutput("t3_gap_gnt", 32'(gnt_o), 32'd2);
        checkOutput("t3_gap_stb", 32'(s_stb_o), 32'd0);
        nextCycle();
        applyStimulus(1, 1, 1, 0, 4'hF, 15'h041, 32'h0);
        pushExpect(1, 1'b0, 32'h55555555);
        sample();
        checkOutput("t3_adr2", 32'(s_adr_o), 32'h041);
        checkOutput("t3_lock_gnt", 32'(gnt_o), 32'd2);
        nextCycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'h55555555;
        sample();
        checkTermination(1, "t3_beat2");
        nextCycle();
        s_ack_i = 1'b0;
        applyStimulus(1, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        checkOutput("t3_rel_gnt", 32'(gnt_o), 32'd2);
        nextCycle();
        sample();
        checkOutput("t3_gap2_gnt", 32'(gnt_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t3_m0_after", 32'(gnt_o), 32'd1);

        // Slave error on the m0 write.
        checkOutput("t4_we", 32'(s_we_o), 32'd1);
        checkOutput("t4_sel", 32'(s_sel_o), 32'hC);
        checkOutput("t4_dat", s_dat_o, 32'hCAFEF00D);
        checkOutput("t4_adr", 32'(s_adr_o), 32'h050);
        nextCycle();
        s_err_i = 1'b1;
        sample();
        checkTermination(0, "t4_err");
        nextCycle();
        s_err_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        nextCycle();
        sample();
        checkOutput("t4_idle_gnt", 32'(gnt_o), 32'd0);

        // Reset in the middle of an m1 transfer.
        nextCycle();
        applyStimulus(1, 1, 1, 0, 4'hF, 15'h060, 32'h0);
        sample();
        nextCycle();
        sample();
        checkOutput("t5_bus1", 32'(gnt_o), 32'd2);
        nextCycle();
        rst_i   = 1'b1;
        s_ack_i = 1'b1;
        sample();
        checkOutput("t5_cyc_now", 32'(s_cyc_o), 32'd0);
        checkOutput("t5_noack_now", termVec(), 32'd0);
        nextCycle();
        sample();
        checkOutput("t5_cyc_after", 32'(s_cyc_o), 32'd0);
        checkOutput("t5_gnt_after", 32'(gnt_o), 32'd0);
        checkOutput("t5_noack_after", termVec(), 32'd0);
        nextCycle();
        rst_i   = 1'b0;
        s_ack_i = 1'b0;
        applyStimulus(0, 1, 1, 0, 4'hF, 15'h070, 32'h0);
        sample();
        checkOutput("t5_rel_gnt", 32'(gnt_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("t5_tie_m0", 32'(gnt_o), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        nextCycle();
        sample();
        checkOutput("t5_idle", 32'(gnt_o), 32'd0);

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: the slave never answers m0, so m1 gets the bus next.
        nextCycle();
        applyStimulus(0, 1, 1, 0, 4'hF, 15'h080, 32'h0);
        pushExpect(0, 1'b1, 32'h0);
        sample();
        nextCycle();
        applyStimulus(1, 1, 1, 0, 4'hF, 15'h090, 32'h0);
        sample();
        checkOutput("t6_stb", 32'(s_stb_o), 32'd1);
        for (int i = 1; i < 15; i++) begin
            nextCycle();
            sample();
            checkOutput("t6_wait", termVec(), 32'd0);
        end
        nextCycle();
        sample();
        checkTermination(0, "t6_timeout");
        checkOutput("t6_cyc_forced", 32'(s_cyc_o), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
        checkOutput("t6_idle", 32'(gnt_o), 32'd0);
        checkOutput("t6_pulse_once", termVec(), 32'd0);
        nextCycle();
        sample();
        checkOutput("t6_m1_next", 32'(gnt_o), 32'd2);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 4'h0, 15'h0, 32'h0);
        sample();
`endif

        checkOutput("sb0_drained", 32'(sbQ0.size()), 32'd0);
        checkOutput("sb1_drained", 32'(sbQ1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_sram_arbiter.md
# wb_sram_arbiter

Two-master Wishbone classic arbiter that shares the single 16-bit external SRAM slave port (`wb_sram16`) between the CPU data port (master 0) and a second bus master such as DMA or video fetch (master 1). It sits between the two masters and the SRAM slave. Grants are made round-robin and locked for the duration of a master's `cyc` assertion. An optional watchdog aborts transfers the slave never acknowledges.

## Interface
- `XLEN`, 32, data width of all data buses.
- `ADDR_BITS`, 17, slave byte-address space; word address buses are `[ADDR_BITS-1:2]`.
- `TIMEOUT`, 15, watchdog limit in cycles. Used only when `WB_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk_i` in 1: sole clock; all state updates on rising edge.
- `rst_i` in 1: **synchronous, active-high** reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 control.
- `m0_sel_i` in 4: master 0 byte selects.
- `m0_adr_i` in ADDR_BITS-2: master 0 word address.
- `m0_dat_i` in XLEN: master 0 write data.
- `m0_dat_o` out XLEN: read data to master 0.
- `m0_ack_o`, `m0_err_o` out 1 each: master 0 termination.
- `m1_*`: identical set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave control.
- `s_sel_o` out 4, `s_adr_o` out ADDR_BITS-2, `s_dat_o` out XLEN: slave request.
- `s_dat_i` in XLEN, `s_ack_i` in 1, `s_err_i` in 1: slave response.
- `gnt_o` out 2: one-hot current grant, `00` when idle.

## Operation
- FSM states: IDLE, BUS0, BUS1. Registered state plus a `last` pointer naming the most recently granted master.
- **Requests:** master n requests when `mn_cyc_i & mn_stb_i`.
- **IDLE:**
  - If exactly one master requests, go to that master's BUS state.
  - If both request, grant the master that is not `last`.
  - On entry to BUSn, `last` is set to n.
- **BUSn:**
  - Slave outputs are muxed combinationally from master n.
  - `mn_ack_o = s_ack_i` and `mn_err_o = s_err_i`.
  - The other master sees ack/err at 0.
  - Grant holds while `mn_cyc_i` is high, so multi-beat or read-modify-write cycles are atomic.
  - When `mn_cyc_i` is low, go to IDLE next cycle. No direct BUS0→BUS1 transition.
- **IDLE outputs:** `s_cyc_o = s_stb_o = s_we_o = 0`, `s_sel_o = 0`, `s_adr_o = 0`, `s_dat_o = 0`.
- **Read data:** `m0_dat_o = m1_dat_o = s_dat_i` always. Only the granted master's ack qualifies it.
- **Masters:** must hold `stb` and request fields stable until ack/err (classic Wishbone). The arbiter performs no buffering.
- **Reset:**
  - All outputs are 0 while `rst_i` is high and on the cycle after.
  - State goes to IDLE and `last` to 1, so master 0 wins the first tie.
  - Reset mid-transfer drops `s_cyc_o` immediately (combinational from state) and generates no ack.

## Timing
- **Arbitration latency:** one cycle. A request seen in IDLE at edge k gives `s_stb_o` high from edge k+1.
- **Ack path:** combinational, zero added latency. Total read latency = 1 + slave latency; for SRAM word access that is 1 + 2 cycles.
- **Release:** `mn_cyc_i` deasserted at edge k → IDLE at k+1 → earliest new grant at k+2.
- **Simultaneous events:** if a new request from master m arrives while master n releases, it is granted at k+2.
- **Starvation bound:** with both masters continuously requesting, grants alternate. No master waits more than one other master's full cycle plus 2 clocks.
- **`gnt_o`:** registered; equals state (BUS0 = `01`, BUS1 = `10`).

## Configuration
- **`WB_ARB_TIMEOUT_EN` defined:**
  - A counter of width `$clog2(TIMEOUT+1)` clears on every grant and on every `s_ack_i` or `s_err_i`.
  - It increments each BUS cycle while `s_stb_o & ~s_ack_i & ~s_err_i`.
  - When it reaches `TIMEOUT`, the granted master receives a one-cycle `mn_err_o`, `s_cyc_o` is forced low that cycle, and the FSM goes to IDLE.
- **Not defined:** no counter is built and the arbiter waits indefinitely for the slave. `TIMEOUT` is ignored.

## Test plan
- **Single master:** m0 reads adr 0x100, slave acks 2 cycles after stb → `s_stb_o` rises 1 cycle after request, `m0_ack_o` pulses with `s_dat_i = 0xDEADBEEF`, `m1_ack_o` stays 0, `gnt_o` = `01` then `00`.
- **Simultaneous after reset:** m0 and m1 request on the same cycle → m0 granted first. m1 granted 2 cycles after m0 drops `cyc`. The next tie goes to m0 (alternation).
- **Lock:** m1 holds `cyc` across two stb/ack beats while m0 requests → `s_adr_o` carries only m1 addresses. m0 is granted only after m1's `cyc` falls.
- **Slave error:** `s_err_i` pulses during a BUS0 write with `sel` = `1100` → `m0_err_o` pulses, `m0_ack_o` stays 0, and `s_sel_o` = `1100` with `s_we_o` = 1 during the transfer.
- **Reset mid-transfer:** `rst_i` asserted while in BUS1 → next cycle `s_cyc_o = 0`, `gnt_o = 00`, no ack to m1. After release, a tie grants m0.
- **Timeout (`WB_ARB_TIMEOUT_EN`, TIMEOUT = 15):** slave never acks → `m0_err_o` pulses exactly 15 cycles after the first `s_stb_o`, the FSM returns to IDLE, and a pending m1 is granted next.
